// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // OR-encoder: each index bit is the OR of the one-hot lines whose position has that bit set.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = idx | (oh[k] ? IDX_W'(k) : '0);
        end
        return idx;
    endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo 8.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx
);

    logic [N_REQ-1:0] rot_req;
    logic [N_REQ-1:0] rot_win;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign rot_req    = N_REQ'({req, req} >> ptr);
    assign rot_win    = rot_req & (~rot_req + N_REQ'(1));
    assign win_onehot = N_REQ'(({rot_win, rot_win} << ptr) >> N_REQ);
    assign win_idx    = onehot_to_idx(win_onehot);
    assign any        = |req;

endmodule : rr_pick8

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant, encoded index and hold-time limit.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             preempt
);

    localparam int HC_W                = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit LIMITED             = (MAX_HOLD != 0);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_SAT = '1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic             preempt_q, preempt_d;

    logic             any;
    logic [N_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;

    // ptr_q is always owner+1 while granted, so one search covers both release and preempt.
    rr_pick8 u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .any        (any),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any)  state_d = GRANT;
            GRANT:   if (!any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic owner_req;
        logic hold_hit;
        logic take_win;

        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        take_win  = 1'b0;
        owner_req = req[idx_q];
        hold_hit  = LIMITED && (hold_q == HOLD_LIM);

        unique case (state_q)
            IDLE: take_win = any;
            GRANT: begin
                if (owner_req && !hold_hit) begin
                    if (hold_q != HOLD_SAT) hold_d = hold_q + HC_W'(1);
                end else if (any) begin
                    take_win  = 1'b1;
                    preempt_d = owner_req && (win_idx != idx_q);
                end else begin
                    gnt_d  = '0;
                    hold_d = '0;
                end
            end
            default: gnt_d = '0;
        endcase

        if (take_win) begin
            gnt_d  = win_onehot;
            idx_d  = win_idx;
            ptr_d  = win_idx + IDX_W'(1);
            hold_d = HC_W'(1);
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;
    assign preempt = preempt_q;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4): per-cycle reference model plus directed literal expectations.
module tb_rr_arbiter8;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: owner -1 means nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_pre   = 0;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int from);
        for (int k = 0; k < 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic rs);
        int w;
        int from;
        bit owner_wants;
        if (!rs) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_pre = 0;
        end else begin
            m_pre = 0;
            owner_wants = (m_owner >= 0) && r[m_owner];
            if (owner_wants && m_hold < MAXH) begin
                m_hold++;
            end else begin
                from = owner_wants ? (m_owner + 1) % 8 : m_ptr;
                w = pick(r, from);
                if (w < 0) begin
                    m_owner = -1;
                end else begin
                    m_pre   = owner_wants && (w != m_owner);
                    m_owner = w;
                    m_ptr   = (w + 1) % 8;
                    m_hold  = 1;
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare on the falling edge.
    task automatic step(input logic [7:0] r, input logic rs);
        logic [7:0] exp_gnt;
        req   = r;
        rst_n = rs;
        @(posedge clk);
        model_edge(r, rs);
        @(negedge clk);
        exp_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("model_gnt", gnt, exp_gnt);
        check("model_vld", gnt_vld, exp_gnt != 0);
        check("model_preempt", preempt, m_pre);
        check("onehot0", $onehot0(gnt), 1);
        if (m_owner >= 0) check("model_idx", gnt_idx, m_owner);
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] s3_idx [9];
        logic       s3_pre [9];

        req   = 8'h00;
        rst_n = 1'b0;

        // Reset with all requests high, then first grant from ptr=0.
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        check("rst_gnt", gnt, 8'h00);
        check("rst_vld", gnt_vld, 0);
        check("rst_pre", preempt, 0);
        check("rst_idx", gnt_idx, 0);
        step(8'hFF, 1'b1);
        check("rst_first_gnt", gnt, 8'h01);
        check("rst_first_idx", gnt_idx, 0);
        step(8'h00, 1'b1);
        check("s1_idle", gnt, 8'h00);

        // Back-to-back hand-over 2 -> 7 -> 2 -> 7, including the 7 -> 0 pointer wrap.
        step(8'h84, 1'b1); check("s2_a_idx", gnt_idx, 2);
        step(8'h84, 1'b1);
        step(8'h84, 1'b1);
        step(8'h80, 1'b1); check("s2_b_idx", gnt_idx, 7); check("s2_b_vld", gnt_vld, 1);
        step(8'h84, 1'b1);
        step(8'h84, 1'b1);
        step(8'h04, 1'b1); check("s2_c_idx", gnt_idx, 2); check("s2_c_vld", gnt_vld, 1);
        step(8'h84, 1'b1);
        step(8'h84, 1'b1);
        step(8'h80, 1'b1); check("s2_d_idx", gnt_idx, 7);
        step(8'h00, 1'b1); check("s2_idle", gnt_vld, 0);

        // Hold limit of 4 under contention between 1 and 4.
        s3_idx = '{1, 1, 1, 1, 4, 4, 4, 4, 1};
        s3_pre = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            step(8'h12, 1'b1);
            check($sformatf("s3_idx_%0d", i), gnt_idx, s3_idx[i]);
            check($sformatf("s3_pre_%0d", i), preempt, s3_pre[i]);
        end
        step(8'h00, 1'b1);

        // Lone requester past the hold limit keeps the grant without preempt.
        for (int i = 0; i < 12; i++) begin
            step(8'h20, 1'b1);
            check($sformatf("s4_gnt_%0d", i), gnt, 8'h20);
            check($sformatf("s4_pre_%0d", i), preempt, 0);
        end
        step(8'h00, 1'b1);

        // Idle return from owner 3, then req[0] wins via wrap from ptr=4.
        step(8'h08, 1'b1); check("s5_own3", gnt_idx, 3);
        step(8'h08, 1'b1);
        step(8'h00, 1'b1); check("s5_idle_gnt", gnt, 8'h00); check("s5_idle_vld", gnt_vld, 0);
        step(8'h01, 1'b1); check("s5_wrap_idx", gnt_idx, 0); check("s5_wrap_vld", gnt_vld, 1);
        step(8'h00, 1'b1);

        // Reset mid-grant drops the grant and restores ptr to 0.
        step(8'h20, 1'b1); check("s6_own5", gnt_idx, 5);
        step(8'h20, 1'b0); check("s6_rst_gnt", gnt, 8'h00);
        step(8'h21, 1'b1); check("s6_after_idx", gnt_idx, 0);
        step(8'h00, 1'b1);
        step(8'h20, 1'b1);
        step(8'h20, 1'b0);
        step(8'h42, 1'b1); check("s6_ptr0_idx", gnt_idx, 1);
        step(8'h00, 1'b1);

        // Mixed traffic with sticky request patterns and occasional resets.
        r = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            step(r, ($urandom_range(0, 59) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter8
